// File: rtl/wave_gen_if.sv
// wave_gen_if: runtime configuration inputs and waveform outputs of wave_gen.
// cyc_cnt exists only when WAVE_GEN_CYCLE_CNT_EN is defined.
interface wave_gen_if #(parameter int DW = 10, parameter int CW = 8);
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] peak;
    logic [DW-1:0] step;
    logic [CW-1:0] dwell;
    logic [DW-1:0] d_out;
    logic [1:0]    phase;
    logic          wrap;
`ifdef WAVE_GEN_CYCLE_CNT_EN
    logic [15:0]   cyc_cnt;
    modport master (output en, mode, peak, step, dwell, input d_out, phase, wrap, cyc_cnt);
    modport slave  (input en, mode, peak, step, dwell, output d_out, phase, wrap, cyc_cnt);
`else
    modport master (output en, mode, peak, step, dwell, input d_out, phase, wrap);
    modport slave  (input en, mode, peak, step, dwell, output d_out, phase, wrap);
`endif
endinterface

// File: rtl/wave_gen.sv
// wave_gen: periodic triangle/trapezoid, sawtooth or square generator with per-period config shadowing.
// Optional WAVE_GEN_CYCLE_CNT_EN adds a 16-bit period counter cyc_cnt.
module wave_gen #(parameter int DW = 10, parameter int CW = 8) (
    input logic       clk,
    input logic       res,
    wave_gen_if.slave bus
);
    typedef enum logic [1:0] {RISE, HOLD_HI, FALL, HOLD_LO} state_t;
    state_t        state, state_n;
    logic [DW-1:0] d_reg, d_n, sh_peak, sh_step, peak_c, step_c;
    logic [CW-1:0] con, con_n, sh_dwell, dwell_c;
    logic [1:0]    sh_mode, mode_c;
    logic          loaded, wrap_reg, wrap_n, reload, square, ramp_fall;
    logic [DW:0]   stp, sum;
    // Until the first enabled clock has captured the shadow, the ports drive the math directly.
    assign mode_c    = loaded ? sh_mode  : bus.mode;
    assign peak_c    = loaded ? sh_peak  : bus.peak;
    assign step_c    = loaded ? sh_step  : bus.step;
    assign dwell_c   = loaded ? sh_dwell : bus.dwell;
    assign stp       = (step_c == '0) ? {{DW{1'b0}}, 1'b1} : {1'b0, step_c};
    assign sum       = {1'b0, d_reg} + stp;
    assign square    = mode_c == 2'd2;
    // Modes 0 and 3 (equal bits) both ramp down; sawtooth and square drop in one clock.
    assign ramp_fall = mode_c[0] == mode_c[1];
    always_comb begin
        state_n = state;
        d_n     = d_reg;
        con_n   = con;
        wrap_n  = 1'b0;
        reload  = 1'b0;
        case (state)
            RISE:
                if (!square && sum < {1'b0, peak_c}) d_n = sum[DW-1:0];
                else begin
                    d_n     = peak_c;
                    state_n = HOLD_HI;
                end
            HOLD_HI:
                if (con == dwell_c) begin
                    con_n   = '0;
                    state_n = FALL;
                end else con_n = con + 1'b1;
            FALL:
                if (ramp_fall && {1'b0, d_reg} > stp) d_n = d_reg - stp[DW-1:0];
                else begin
                    d_n     = '0;
                    state_n = HOLD_LO;
                end
            HOLD_LO:
                if (con == dwell_c) begin
                    con_n   = '0;
                    state_n = RISE;
                    wrap_n  = 1'b1;
                    reload  = 1'b1;
                end else con_n = con + 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= RISE;
            d_reg    <= '0;
            con      <= '0;
            wrap_reg <= 1'b0;
            loaded   <= 1'b0;
            sh_mode  <= '0;
            sh_peak  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
        end else if (bus.en) begin
            state    <= state_n;
            d_reg    <= d_n;
            con      <= con_n;
            wrap_reg <= wrap_n;
            if (!loaded || reload) begin
                loaded   <= 1'b1;
                sh_mode  <= bus.mode;
                sh_peak  <= bus.peak;
                sh_step  <= bus.step;
                sh_dwell <= bus.dwell;
            end
        end else wrap_reg <= 1'b0;
    end
`ifdef WAVE_GEN_CYCLE_CNT_EN
    logic [15:0] cyc_reg;
    always_ff @(posedge clk or negedge res) begin
        if (!res) cyc_reg <= '0;
        else if (bus.en && wrap_n) cyc_reg <= cyc_reg + 16'd1;
    end
    assign bus.cyc_cnt = cyc_reg;
`endif
    assign bus.d_out = d_reg;
    assign bus.phase = state;
    assign bus.wrap  = wrap_reg;
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed scenarios plus randomized run against a period-list reference model.
module tb_wave_gen;
    typedef struct packed { logic [1:0] ph; logic [9:0] d; } samp_t;
    logic clk = 1'b0;
    logic res = 1'b0;
    int checks = 0;
    int failures = 0;
    samp_t exp_q[$];
    wave_gen_if #(.DW(10), .CW(8)) bus ();
    wave_gen #(.DW(10), .CW(8)) dut (.clk(clk), .res(res), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int m, input int pk, input int st, input int dw);
        bus.mode  = 2'(m);
        bus.peak  = 10'(pk);
        bus.step  = 10'(st);
        bus.dwell = 8'(dw);
    endtask

    task automatic do_reset();
        res = 1'b0;
        tick();
        tick();
        res = 1'b1;
    endtask

    task automatic push(input int ph, input int d);
        samp_t s;
        s.ph = 2'(ph);
        s.d  = 10'(d);
        exp_q.push_back(s);
    endtask

    // One full period as a list of (phase, level) samples, starting at the RISE/0 sample.
    task automatic gen_period(input int m, input int pk, input int st, input int dw);
        int s;
        s = (st == 0) ? 1 : st;
        push(0, 0);
        if (m != 2) for (int v = s; v < pk; v += s) push(0, v);
        for (int i = 0; i <= dw; i++) push(1, pk);
        push(2, pk);
        if (m == 0 || m == 3) for (int v = pk - s; v > 0; v -= s) push(2, v);
        for (int i = 0; i <= dw; i++) push(3, 0);
    endtask

    task automatic test_reset();
        bus.en = 1'b1;
        set_cfg(0, 20, 7, 2);
        #2;
        checks++;
        if (bus.d_out !== 10'd0 || bus.phase !== 2'd0 || bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial d_out=%0d phase=%0d wrap=%0d exp 0/0/0", bus.d_out, bus.phase, bus.wrap);
        end
        tick();
        tick();
        checks++;
        if (bus.d_out !== 10'd0 || bus.phase !== 2'd0) begin
            failures++;
            $display("FAIL reset_held d_out=%0d phase=%0d exp 0/0", bus.d_out, bus.phase);
        end
`ifdef WAVE_GEN_CYCLE_CNT_EN
        checks++;
        if (bus.cyc_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cyc_cnt got=%0d exp=0", bus.cyc_cnt);
        end
`endif
    endtask

    task automatic test_triangle();
        int wraps = 0, w1 = 0, w2 = 0;
        set_cfg(0, 299, 1, 200);
        do_reset();
        for (int i = 1; i <= 2100; i++) begin
            tick();
            if (bus.wrap === 1'b1) begin
                wraps++;
                if (wraps == 1) w1 = i;
                if (wraps == 2) w2 = i;
            end
            if (i == 298 || i == 299 || i == 500 || i == 799) begin
                int ed, ep;
                ed = (i == 298) ? 298 : (i == 799) ? 0 : 299;
                ep = (i == 298) ? 0 : (i == 299) ? 1 : (i == 500) ? 2 : 3;
                checks++;
                if (bus.d_out !== 10'(ed) || bus.phase !== 2'(ep)) begin
                    failures++;
                    $display("FAIL tri_clk%0d d_out=%0d phase=%0d exp %0d/%0d", i, bus.d_out, bus.phase, ed, ep);
                end
            end
        end
        checks++;
        if (wraps != 2 || w1 != 1000 || w2 != 2000) begin
            failures++;
            $display("FAIL tri_period wraps=%0d at %0d,%0d exp 2 at 1000,2000", wraps, w1, w2);
        end
    endtask

    task automatic test_seq();
        int ed[12], ep[12];
        ed = '{0, 7, 14, 20, 20, 20, 20, 13, 6, 0, 0, 0};
        ep = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        set_cfg(0, 20, 7, 2);
        do_reset();
        for (int i = 0; i <= 25; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.d_out !== 10'(ed[i % 12]) || bus.phase !== 2'(ep[i % 12]) ||
                bus.wrap !== (i > 0 && i % 12 == 0)) begin
                failures++;
                $display("FAIL seq_clk%0d d_out=%0d phase=%0d wrap=%0d exp %0d/%0d", i, bus.d_out,
                         bus.phase, bus.wrap, ed[i % 12], ep[i % 12]);
            end
        end
    endtask

    task automatic test_saw_square();
        int es[8], eq[4];
        es = '{0, 1, 2, 3, 4, 5, 5, 0};
        eq = '{0, 5, 5, 0};
        set_cfg(1, 5, 1, 0);
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.d_out !== 10'(es[i % 8])) begin
                failures++;
                $display("FAIL saw_clk%0d d_out=%0d exp=%0d", i, bus.d_out, es[i % 8]);
            end
        end
        set_cfg(2, 5, 1, 0);
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.d_out !== 10'(eq[i % 4])) begin
                failures++;
                $display("FAIL square_clk%0d d_out=%0d exp=%0d", i, bus.d_out, eq[i % 4]);
            end
        end
    endtask

    task automatic test_shadow();
        int n;
        set_cfg(0, 299, 1, 0);
        do_reset();
        repeat (100) tick();
        bus.peak = 10'd100;
        n = 0;
        while (bus.phase !== 2'd1 && n < 1000) begin tick(); n++; end
        checks++;
        if (bus.d_out !== 10'd299) begin
            failures++;
            $display("FAIL shadow_cur_peak d_out=%0d exp=299", bus.d_out);
        end
        n = 0;
        while (bus.wrap !== 1'b1 && n < 1000) begin tick(); n++; end
        n = 0;
        while (bus.phase !== 2'd1 && n < 1000) begin tick(); n++; end
        checks++;
        if (bus.d_out !== 10'd100 || bus.phase !== 2'd1) begin
            failures++;
            $display("FAIL shadow_next_peak d_out=%0d phase=%0d exp 100/1", bus.d_out, bus.phase);
        end
    endtask

    task automatic test_freeze();
        set_cfg(0, 299, 1, 5);
        do_reset();
        repeat (150) tick();
        bus.en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (bus.d_out !== 10'd150 || bus.phase !== 2'd0 || bus.wrap !== 1'b0) begin
                failures++;
                $display("FAIL freeze_clk%0d d_out=%0d phase=%0d exp 150/0", i, bus.d_out, bus.phase);
            end
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.d_out !== 10'd151 || bus.phase !== 2'd0) begin
            failures++;
            $display("FAIL freeze_resume d_out=%0d phase=%0d exp 151/0", bus.d_out, bus.phase);
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(0, 299, 1, 200);
        do_reset();
        repeat (1599) tick();
        checks++;
        if (bus.d_out !== 10'd200 || bus.phase !== 2'd2) begin
            failures++;
            $display("FAIL mid_pre d_out=%0d phase=%0d exp 200/2", bus.d_out, bus.phase);
        end
        #2 res = 1'b0;
        #1;
        checks++;
        if (bus.d_out !== 10'd0 || bus.phase !== 2'd0 || bus.wrap !== 1'b0) begin
            failures++;
            $display("FAIL mid_async d_out=%0d phase=%0d wrap=%0d exp 0/0/0", bus.d_out, bus.phase, bus.wrap);
        end
`ifdef WAVE_GEN_CYCLE_CNT_EN
        checks++;
        if (bus.cyc_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_cyc_clear got=%0d exp=0", bus.cyc_cnt);
        end
`endif
        res = 1'b1;
        repeat (3000) tick();
        checks++;
        if (bus.wrap !== 1'b1 || bus.d_out !== 10'd0 || bus.phase !== 2'd0) begin
            failures++;
            $display("FAIL mid_restart wrap=%0d d_out=%0d phase=%0d exp 1/0/0", bus.wrap, bus.d_out, bus.phase);
        end
`ifdef WAVE_GEN_CYCLE_CNT_EN
        checks++;
        if (bus.cyc_cnt !== 16'd3) begin
            failures++;
            $display("FAIL mid_cyc_cnt got=%0d exp=3", bus.cyc_cnt);
        end
`endif
    endtask

    task automatic test_random();
        samp_t cur;
        logic w_exp;
        bit first, en_now;
        for (int r = 0; r < 6; r++) begin
            bus.en = 1'b1;
            set_cfg($urandom_range(0, 3), $urandom_range(0, 60), $urandom_range(0, 70), $urandom_range(0, 4));
            do_reset();
            exp_q.delete();
            first = 1'b1;
            for (int i = 0; i < 400; i++) begin
                bus.en = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 3) == 0)
                    set_cfg($urandom_range(0, 3), $urandom_range(0, 60), $urandom_range(0, 70), $urandom_range(0, 4));
                en_now = bus.en;
                w_exp = 1'b0;
                if (en_now && exp_q.size() == 0) begin
                    gen_period(int'(bus.mode), int'(bus.peak), int'(bus.step), int'(bus.dwell));
                    if (first) cur = exp_q.pop_front();
                    w_exp = !first;
                    first = 1'b0;
                end
                tick();
                if (en_now) cur = exp_q.pop_front();
                else if (first) cur = '0;
                checks++;
                if (bus.d_out !== cur.d || bus.phase !== cur.ph || bus.wrap !== w_exp) begin
                    failures++;
                    $display("FAIL rand_r%0d_clk%0d d_out=%0d phase=%0d wrap=%0d exp %0d/%0d/%0d", r, i,
                             bus.d_out, bus.phase, bus.wrap, cur.d, cur.ph, w_exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_seq();
        test_saw_square();
        test_shadow();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
